// File: rtl/uart9_pkg.sv
// Definitions shared by the 9-bit-over-UART receiver and transmitter:
// the FSM state encoding and the baud divisor helper.
package uart9_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT2
  } state_t;

  // Clocks per bit, integer-truncated.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Front end of the UART receiver: rx synchroniser, falling-edge detect, baud counter and bit sampling.
// Define UART9_RX_MAJORITY_EN for a 2-of-3 vote around each sample point (needs DIV >= 4).
module uart_bit_sampler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic run,
  input  logic start_phase,
  output logic fall_edge,
  output logic sample_stb,
  output logic sample_val
);

  localparam int HALF = DIV / 2;
`ifdef UART9_RX_MAJORITY_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] START_LAST = CW'(HALF - 1 + EXTRA);
  localparam logic [CW-1:0] BIT_LAST   = CW'(DIV - 1);

  logic          sync1;
  logic          rxs;
  logic          rxs_d;
  logic [1:0]    live;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last_cnt;

  // NOTE: the synchroniser resets to the idle level (1), so a reset line looks idle, not like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b0;
      live  <= 2'b00;
    end else begin
      sync1 <= rx;
      rxs   <= sync1;
      live  <= {live[0], 1'b1};
      // Only a genuinely observed high can arm the edge detector; a line held low through reset is ignored.
      rxs_d <= rxs & live[1];
    end
  end

  assign fall_edge  = rxs_d & ~rxs;
  assign last_cnt   = start_phase ? START_LAST : BIT_LAST;
  assign sample_stb = run && (cnt == last_cnt);

  // Counter restarts on every strobe, which coincides with each FSM state/bit boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || sample_stb) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

`ifdef UART9_RX_MAJORITY_EN
  logic s0;
  logic s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
    end else if (run) begin
      if (cnt == last_cnt - CW'(2)) s0 <= rxs;
      if (cnt == last_cnt - CW'(1)) s1 <= rxs;
    end
  end

  assign sample_val = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
`else
  assign sample_val = rxs;
`endif

endmodule

// File: rtl/uart9_rx.sv
// 9-bit word receiver: two 8N1 bytes (low byte, then {7'b0, bit8}) reassembled into data9 with a valid strobe.
// Optional UART9_RX_MAJORITY_EN selects majority-vote sampling in uart_bit_sampler.
module uart9_rx
  import uart9_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [8:0] data9,
  output logic       valid,
  output logic       frame_err,
  output logic       timeout_err,
  output logic       busy
);

  localparam int DIV     = calc_div(CLK_HZ, BAUD);
  localparam int TO_CLKS = TIMEOUT_BITS * DIV;
  localparam int TW      = $clog2(TO_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CLKS - 1);

  state_t        state;
  logic          byte1;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    lo;
  logic [TW-1:0] tcnt;
  logic          fall_edge;
  logic          sample_stb;
  logic          sample_val;
  logic          run;

  assign run = (state == START) || (state == DATA) || (state == STOP);

  uart_bit_sampler #(
    .DIV(DIV)
  ) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .run        (run),
    .start_phase(state == START),
    .fall_edge  (fall_edge),
    .sample_stb (sample_stb),
    .sample_val (sample_val)
  );

  // NOTE: every output is assigned here with <= so strobes and data9 are registered and glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      byte1       <= 1'b0;
      bit_idx     <= '0;
      shift       <= '0;
      lo          <= '0;
      tcnt        <= '0;
      data9       <= '0;
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      valid       <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
      case (state)
        IDLE: begin
          byte1 <= 1'b0;
          if (fall_edge) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: if (sample_stb) begin
          if (!sample_val) begin
            state   <= DATA;
            bit_idx <= '0;
          end else if (byte1) begin
            state <= WAIT2;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: if (sample_stb) begin
          shift[bit_idx] <= sample_val;
          if (bit_idx == 3'd7) state <= STOP;
          else bit_idx <= bit_idx + 3'd1;
        end
        STOP: if (sample_stb) begin
          if (!sample_val) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (!byte1) begin
            lo    <= shift;
            byte1 <= 1'b1;
            state <= WAIT2;
          end else begin
            // High byte must be {7'b0, bit8}; anything else poisons the pair.
            if (shift[7:1] == 7'd0) begin
              data9 <= {shift[0], lo};
              valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        WAIT2: begin
          if (fall_edge) begin
            state <= START;
          end else if (tcnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart9_rx.sv
// Directed bench for uart9_rx at CLK_HZ=1 MHz, BAUD=100 kbaud (10 clocks per bit).
module tb_uart9_rx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DIV    = 10;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [8:0] data9;
  logic       valid;
  logic       frame_err;
  logic       timeout_err;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_tout  = 0;
  logic [8:0] words[$];
  time        t_tout  = 0;
  logic       prev_valid = 1'b0;
  logic       busy_after_valid = 1'bx;

  uart9_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data9      (data9),
    .valid      (valid),
    .frame_err  (frame_err),
    .timeout_err(timeout_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (valid) begin
      n_valid++;
      words.push_back(data9);
    end
    if (frame_err) n_ferr++;
    if (timeout_err) begin
      n_tout++;
      t_tout = $time;
    end
    if (prev_valid) busy_after_valid = busy;
    prev_valid = valid;
    if (valid || frame_err || timeout_err) begin
      vectors++;
      if ((int'(valid) + int'(frame_err) + int'(timeout_err)) > 1) begin
        miscompares++;
        $display("FAIL strobe_exclusive: valid=%b frame_err=%b timeout_err=%b, required at most one", valid, frame_err, timeout_err);
      end
    end
  end

  task automatic clear_counts();
    n_valid = 0;
    n_ferr  = 0;
    n_tout  = 0;
    words.delete();
    busy_after_valid = 1'bx;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic send_pair(input logic [8:0] w);
    send_byte(w[7:0], 1'b1);
    send_byte({7'd0, w[8]}, 1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (data9 !== 9'h000) begin miscompares++; $display("FAIL reset_data9: got %h want 000", data9); end
    vectors++;
    if ({valid, frame_err, timeout_err, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got v/f/t/b=%b want 0000", {valid, frame_err, timeout_err, busy});
    end
    reset = 1'b0;
    idle_bits(3);
  endtask

  task automatic test_basic();
    clear_counts();
    send_byte(8'hA5, 1'b1);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_between_bytes: got %b want 1", busy); end
    send_byte(8'h01, 1'b1);
    idle_bits(3);
    vectors++;
    if (n_valid !== 1) begin miscompares++; $display("FAIL basic_valid_count: got %0d want 1", n_valid); end
    vectors++;
    if (data9 !== 9'h1A5) begin miscompares++; $display("FAIL basic_data9: got %h want 1a5", data9); end
    vectors++;
    if (n_ferr + n_tout !== 0) begin miscompares++; $display("FAIL basic_errors: got %0d want 0", n_ferr + n_tout); end
    vectors++;
    if (busy_after_valid !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after_valid: got %b want 0", busy_after_valid); end
  endtask

  task automatic test_back_to_back();
    clear_counts();
    send_pair(9'h000);
    send_pair(9'h1FF);
    idle_bits(3);
    vectors++;
    if (words.size() !== 2) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d words want 2", words.size());
    end else begin
      vectors++;
      if (words[0] !== 9'h000) begin miscompares++; $display("FAIL b2b_word0: got %h want 000", words[0]); end
      vectors++;
      if (words[1] !== 9'h1FF) begin miscompares++; $display("FAIL b2b_word1: got %h want 1ff", words[1]); end
    end
  endtask

  task automatic test_timeout();
    time t_start;
    clear_counts();
    t_start = $time;
    send_byte(8'h3C, 1'b1);
    idle_bits(25);
    vectors++;
    if (n_tout !== 1) begin miscompares++; $display("FAIL timeout_count: got %0d want 1", n_tout); end
    // Stop sample lands ~98 clocks after the start bit, expiry 200 clocks later.
    vectors++;
    if (n_tout == 1 && ((t_tout - t_start) / 10 < 296 || (t_tout - t_start) / 10 > 302)) begin
      miscompares++;
      $display("FAIL timeout_timing: got %0d clks want 296..302", (t_tout - t_start) / 10);
    end
    vectors++;
    if (n_valid !== 0) begin miscompares++; $display("FAIL timeout_no_valid: got %0d want 0", n_valid); end
    vectors++;
    if (data9 !== 9'h1FF) begin miscompares++; $display("FAIL timeout_data9_held: got %h want 1ff", data9); end
  endtask

  task automatic test_stop_err();
    clear_counts();
    send_byte(8'hA5, 1'b0);
    idle_bits(3);
    vectors++;
    if (n_ferr !== 1) begin miscompares++; $display("FAIL stop_err_count: got %0d want 1", n_ferr); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL stop_err_idle: busy got %b want 0", busy); end
    send_pair(9'h055);
    idle_bits(3);
    vectors++;
    if (words.size() !== 1 || data9 !== 9'h055) begin
      miscompares++;
      $display("FAIL stop_err_recover: got %0d words data9=%h want 1 word 055", words.size(), data9);
    end
  endtask

  task automatic test_byte1_err();
    clear_counts();
    send_byte(8'h10, 1'b1);
    send_byte(8'h03, 1'b1);
    idle_bits(3);
    vectors++;
    if (n_ferr !== 1) begin miscompares++; $display("FAIL byte1_err_count: got %0d want 1", n_ferr); end
    vectors++;
    if (n_valid !== 0) begin miscompares++; $display("FAIL byte1_err_no_valid: got %0d want 0", n_valid); end
    vectors++;
    if (data9 !== 9'h055) begin miscompares++; $display("FAIL byte1_err_data9_held: got %h want 055", data9); end
  endtask

  task automatic test_glitch();
    clear_counts();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_busy: got %b want 0", busy); end
    idle_bits(3);
    vectors++;
    if (n_valid + n_ferr + n_tout !== 0) begin
      miscompares++;
      $display("FAIL glitch_strobes: got %0d want 0", n_valid + n_ferr + n_tout);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    send_byte(8'h77, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    reset = 1'b1;
    rx    = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (data9 !== 9'h000) begin miscompares++; $display("FAIL midreset_data9: got %h want 000", data9); end
    vectors++;
    if ({valid, frame_err, timeout_err, busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL midreset_flags: got v/f/t/b=%b want 0000", {valid, frame_err, timeout_err, busy});
    end
    reset = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL held_low_not_start: busy got %b want 0", busy); end
    idle_bits(2);
    send_pair(9'h123);
    idle_bits(3);
    vectors++;
    if (words.size() !== 1 || data9 !== 9'h123) begin
      miscompares++;
      $display("FAIL midreset_recover: got %0d words data9=%h want 1 word 123", words.size(), data9);
    end
    vectors++;
    if (n_ferr + n_tout !== 0) begin miscompares++; $display("FAIL midreset_errors: got %0d want 0", n_ferr + n_tout); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_stop_err();
    test_byte1_err();
    test_glitch();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
